// File: rtl/comms_frame_rx.sv
// rtl/comms_frame_rx.sv - framed receive stage: SOF/length/payload/checksum parse, buffered drain
// Optional checksum byte and CHK state enabled by defining COMMS_RX_CHECKSUM_EN.
module comms_frame_rx #(
    parameter int         MAX_LEN = 16,
    parameter logic [7:0] SOF     = 8'hA5
) (
    input  logic       clk_bar,
    input  logic       clr_bar,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);
    localparam int         AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_L = 8'(MAX_LEN);

    typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHK, DRAIN} state_t;

    state_t     state, state_nxt;
    logic [7:0] buffer [MAX_LEN];
    logic [7:0] len, idx, rd;
    logic       ovr;
    logic       ok_nxt, err_nxt;
    logic [1:0] code_nxt;
    logic       xfer;
`ifdef COMMS_RX_CHECKSUM_EN
    logic [7:0] csum;
`endif

    assign out_valid = (state == DRAIN);
    assign out_data  = out_valid ? buffer[rd[AW-1:0]] : 8'h00;
    assign out_last  = out_valid && (rd == len - 8'd1);
    assign busy      = (state != IDLE);
    assign xfer      = out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        ok_nxt    = 1'b0;
        err_nxt   = 1'b0;
        code_nxt  = err_code;
        case (state)
            IDLE: if (rx_valid && rx_data == SOF) state_nxt = LEN;
            LEN: begin
                if (rx_valid) begin
                    if (rx_data == 8'd0 || rx_data > MAX_L) begin
                        err_nxt   = 1'b1;
                        code_nxt  = 2'b01;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (rx_valid && idx == len - 8'd1) begin
`ifdef COMMS_RX_CHECKSUM_EN
                    state_nxt = CHK;
`else
                    state_nxt = DRAIN;
                    ok_nxt    = 1'b1;
`endif
                end
            end
            CHK: begin
`ifdef COMMS_RX_CHECKSUM_EN
                if (rx_valid) begin
                    if (rx_data == csum) begin
                        ok_nxt    = 1'b1;
                        state_nxt = DRAIN;
                    end else begin
                        err_nxt   = 1'b1;
                        code_nxt  = 2'b10;
                        state_nxt = IDLE;
                    end
                end
`else
                state_nxt = IDLE;
`endif
            end
            DRAIN: begin
                // Bytes arriving while draining are dropped; only the first one is reported.
                if (rx_valid && !ovr) begin
                    err_nxt  = 1'b1;
                    code_nxt = 2'b11;
                end
                if (xfer && out_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_bar or negedge clr_bar) begin
        if (!clr_bar) begin
            state     <= IDLE;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'b00;
            len       <= 8'd0;
            idx       <= 8'd0;
            rd        <= 8'd0;
            ovr       <= 1'b0;
`ifdef COMMS_RX_CHECKSUM_EN
            csum      <= 8'd0;
`endif
        end else begin
            state     <= state_nxt;
            frame_ok  <= ok_nxt;
            frame_err <= err_nxt;
            err_code  <= code_nxt;
            if (state == LEN && rx_valid) begin
                len <= rx_data;
                idx <= 8'd0;
`ifdef COMMS_RX_CHECKSUM_EN
                csum <= rx_data;
`endif
            end
            if (state == PAYLOAD && rx_valid) begin
                idx <= idx + 8'd1;
`ifdef COMMS_RX_CHECKSUM_EN
                csum <= csum ^ rx_data;
`endif
            end
            if (state != DRAIN && state_nxt == DRAIN) begin
                rd  <= 8'd0;
                ovr <= 1'b0;
            end else if (state == DRAIN) begin
                if (rx_valid) ovr <= 1'b1;
                if (xfer) rd <= rd + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_bar) begin
        if (state == PAYLOAD && rx_valid) buffer[idx[AW-1:0]] <= rx_data;
    end
endmodule

// File: doc/comms_frame_rx.md
# comms_frame_rx

Framed receive stage sitting directly downstream of the receiver XOR stage in the two-stage comms link. Consumes the decrypted byte stream, locates frames (start byte, length, payload, checksum), holds each frame in an internal buffer until it is validated, then releases the payload through a valid/ready interface. Bad or overrunning frames are discarded whole and reported through a one-cycle error pulse and an error code.

## Interface
- `MAX_LEN`, 16: maximum payload length in bytes; range 1..255; sets the frame buffer depth.
- `SOF`, 8'hA5: start-of-frame byte value.
- `clk_bar` in 1: clock; all registers update on its rising edge.
- `clr_bar` in 1: asynchronous, active-low reset.
- `rx_valid` in 1: `rx_data` holds a byte this cycle; single-cycle qualifier, no backpressure upstream.
- `rx_data` in 8: decrypted byte from the receiver.
- `out_valid` out 1: `out_data` valid.
- `out_data` out 8: payload byte.
- `out_last` out 1: final payload byte of the frame; qualified by `out_valid`.
- `out_ready` in 1: consumer accepts the byte when high with `out_valid`.
- `frame_ok` out 1: one-cycle pulse when a frame validates.
- `frame_err` out 1: one-cycle pulse when a frame is discarded.
- `err_code` out 2: cause of the most recent `frame_err`; held until the next error: 01 bad length, 10 checksum mismatch, 11 overrun.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, LEN, PAYLOAD, CHK, DRAIN.
- IDLE: on an `rx_valid` byte equal to `SOF` -> LEN; other bytes are ignored silently.
- LEN: on the next byte, L = byte. L = 0 or L > `MAX_LEN` -> `frame_err`, `err_code`=01, go to IDLE. Otherwise store L, seed checksum = L, clear the write index, go to PAYLOAD.
- PAYLOAD: each byte is written to buffer[idx], idx increments, and checksum ^= byte. After the L-th byte -> CHK.
- CHK: the next byte is compared with the checksum. On a match, `frame_ok` pulses and the state goes to DRAIN with the read index at 0. On a mismatch, `frame_err` pulses, `err_code`=10, and the state goes to IDLE.
- DRAIN: `out_valid`=1 and `out_data`=buffer[rd]. A transfer (`out_valid`&`out_ready`) increments rd. `out_last`=1 when rd = L-1. The transfer with `out_last` -> IDLE.
- Overrun: any `rx_valid` byte arriving in DRAIN is dropped. On the first one, `frame_err` pulses and `err_code` is set to 11. The current frame is still drained completely; the dropped byte never starts a frame.
- `SOF` values inside LEN, PAYLOAD, and CHK are treated as data; there is no resynchronisation mid-frame.
- The checksum is an 8-bit XOR; there is no width growth.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_last`=0, `frame_ok`=0, `frame_err`=0, `err_code`=00, `busy`=0, state=IDLE, all indices 0.
- Reset asserted mid-frame or mid-drain clears all outputs and state immediately (asynchronously). The buffered frame is lost.
- `busy` rises the cycle after the `SOF` byte is accepted.
- `frame_ok` is registered and high the cycle after the checksum byte is sampled. `out_valid` rises in that same cycle.
- Drain throughput is 1 byte per cycle while `out_ready`=1. `out_data`, `out_valid`, and `out_last` stay stable while `out_ready`=0.
- After the last transfer, `busy`=0 and IDLE accepts `SOF` in the following cycle.
- Minimum frame is 4 bytes (`SOF`, L=1, payload, checksum). Back-to-back frames are accepted only after DRAIN completes.

## Configuration
- `COMMS_RX_CHECKSUM_EN` defined: the CHK state and checksum byte exist exactly as described above.
- `COMMS_RX_CHECKSUM_EN` undefined:
  - There is no checksum byte. After the L-th payload byte, the block goes directly to DRAIN and `frame_ok` pulses in the same cycle `out_valid` first rises.
  - `err_code` 10 is never produced.

## Test plan
- Valid frame (defaults, checksum enabled): `rx` A5 03 11 22 33 03, `out_ready`=1. Output is 11, 22, 33 on consecutive cycles with `out_last` on 33, one `frame_ok`, no `frame_err`.
- Bad checksum: A5 03 11 22 33 04. No `out_valid`, `frame_err` pulses once, `err_code`=10, `busy` returns to 0.
- Bad length: A5 00, then A5 11 (17 > `MAX_LEN`). Two `frame_err` pulses with `err_code`=01 each. A following valid frame A5 01 7E 7F outputs 7E with `out_last`.
- Backpressure plus overrun: valid frame A5 02 AA BB 13 with `out_ready`=0 for 5 cycles, and an `rx_valid` byte 55 injected during DRAIN. `out_data` holds AA, `frame_err` pulses with `err_code`=11, then AA and BB drain once `out_ready`=1.
- Reset mid-payload: deassert `clr_bar` after A5 03 11. All outputs go to reset values at once. A later A5 01 42 43 outputs 42.
- Checksum disabled build: A5 02 C3 3C. Output is C3, 3C with `out_last` on 3C, one `frame_ok`.
